hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RV32 core.
- Detects load-use hazards, taken branch/jump redirects from EX, and multi-cycle data-memory waits.
- Drives the PC, IF/ID, ID/EX and EX/MEM write enables, the IF/ID flush, and the bubble select into the control-zeroing mux.
- Keeps a memory-wait watchdog and a saturating stall counter.

---
 rtl/hazard_pkg.sv | 47 ++++
 rtl/hazard_lu_cmp.sv | 31 +++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constant control patterns for the pipeline hazard controller.
// The control bundle is the set of pipeline register enables plus the flush and bubble selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic bubble_sel;
        logic id_ex_write;
        logic ex_mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      bubble_sel: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                      bubble_sel: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1};
    localparam ctrl_t CTRL_LU     = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      bubble_sel: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      bubble_sel: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0};
    localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      bubble_sel: 1'b1, id_ex_write: 1'b0, ex_mem_write: 1'b0};

    // Control pattern when no memory wait is pending: a taken branch squashes ID,
    // so it overrides any load-use hazard on the same cycle.
    function automatic ctrl_t run_ctrl(input logic branch, input logic lu);
        ctrl_t c;
        if (branch) begin
            c = CTRL_BRANCH;
        end else if (lu) begin
            c = CTRL_LU;
        end else begin
            c = CTRL_NORMAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_lu_cmp.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
// Writes to x0 are discarded by the register file, so they never create a dependency.
module hazard_lu_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    output logic       lu_o
);

    logic [1:0][4:0] src_reg;
    logic [1:0]      src_used;
    logic [1:0]      src_hit;

    assign src_reg  = {id_rs2_i, id_rs1_i};
    assign src_used = {id_uses_rs2_i, id_uses_rs1_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_reg[gi] == ex_rd_i);
        end
    endgenerate

    assign lu_o = ex_mem_read_i && (ex_rd_i != REG_X0) && (|src_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: Mealy enables from a RUN/MEM_WAIT/ERR FSM,
// with a data-memory wait watchdog and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 15,
    parameter int WAIT_W       = 4,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   bubble_sel,
    output logic                   id_ex_write,
    output logic                   ex_mem_write,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);

    state_e                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic                   mem_timeout_q, mem_timeout_d;

    ctrl_t ctrl;
    ctrl_t ctrl_out;
    logic  lu;
    logic  mw;

    hazard_lu_cmp u_lu_cmp (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .lu_o          (lu)
    );

    assign mw = mem_req && !mem_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        ctrl          = CTRL_FREEZE;

        case (state_q)
            RUN: begin
                if (mw) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    ctrl = run_ctrl(ex_branch_taken, lu);
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    // The counter holds at its limit on timeout; ERR never reads it.
                    if (wait_cnt_q == WAIT_W'(MAX_MEM_WAIT)) begin
                        state_d       = ERR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    ctrl       = run_ctrl(ex_branch_taken, lu);
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!ctrl.pc_write && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Reset overrides the combinational controls so the pipeline holds with a bubble.
    assign ctrl_out     = rst_n ? ctrl : CTRL_RESET;
    assign pc_write     = ctrl_out.pc_write;
    assign if_id_write  = ctrl_out.if_id_write;
    assign if_id_flush  = ctrl_out.if_id_flush;
    assign bubble_sel   = ctrl_out.bubble_sel;
    assign id_ex_write  = ctrl_out.id_ex_write;
    assign ex_mem_write = ctrl_out.ex_mem_write;
    assign mem_timeout  = mem_timeout_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expectations queued at drive time, popped and
// compared against the combinational controls and the post-edge registered outputs.
module tb_hazard_ctrl;

    localparam logic [5:0] E_NORM = 6'b110011;
    localparam logic [5:0] E_FRZ  = 6'b000000;
    localparam logic [5:0] E_BR   = 6'b111111;
    localparam logic [5:0] E_LU   = 6'b000111;
    localparam logic [5:0] E_RST  = 6'b000100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic        mem_req, mem_ready;
    logic        pc_write, if_id_write, if_id_flush, bubble_sel, id_ex_write, ex_mem_write;
    logic        mem_timeout;
    logic [15:0] stall_count;
    logic [5:0]  obs_ctrl;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [5:0]  ctrl;
        logic [15:0] stall;
        logic        to;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MAX_MEM_WAIT (15),
        .WAIT_W       (4),
        .STALL_CNT_W  (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .bubble_sel      (bubble_sel),
        .id_ex_write     (id_ex_write),
        .ex_mem_write    (ex_mem_write),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count)
    );

    assign obs_ctrl = {pc_write, if_id_write, if_id_flush, bubble_sel, id_ex_write, ex_mem_write};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called just after a falling edge: drive, compare controls mid-low-phase,
    // then compare registered outputs 1 time unit after the rising edge.
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic req, input logic rdy,
                        input logic [5:0] e_ctrl, input int e_stall, input logic e_to);
        exp_t e;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br;
        mem_req = req; mem_ready = rdy;
        e.tag = tag; e.ctrl = e_ctrl; e.stall = 16'(e_stall); e.to = e_to;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        check({e.tag, ".ctrl"}, 32'(obs_ctrl), 32'(e.ctrl));
        @(posedge clk);
        #1;
        check({e.tag, ".stall"}, 32'(stall_count), 32'(e.stall));
        check({e.tag, ".timeout"}, 32'(mem_timeout), 32'(e.to));
        @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".ctrl"}, 32'(obs_ctrl), 32'(E_RST));
        check({tag, ".stall"}, 32'(stall_count), 32'd0);
        check({tag, ".timeout"}, 32'(mem_timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;

        reset_check("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //    tag              rs1    rs2    u1 u2 rd     mr br req rdy ctrl   stall to
        step("normal",        5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 0, 0, E_NORM, 0, 0);
        step("lu_rs1",        5'd5,  5'd2,  1, 0, 5'd5,  1, 0, 0, 0, E_LU,   1, 0);
        step("lu_rs1_after",  5'd5,  5'd2,  1, 0, 5'd5,  0, 0, 0, 0, E_NORM, 1, 0);
        step("x0_no_stall",   5'd0,  5'd2,  1, 0, 5'd0,  1, 0, 0, 0, E_NORM, 1, 0);
        step("rs2_unused",    5'd3,  5'd7,  1, 0, 5'd7,  1, 0, 0, 0, E_NORM, 1, 0);
        step("lu_rs2",        5'd3,  5'd7,  1, 1, 5'd7,  1, 0, 0, 0, E_LU,   2, 0);
        step("branch_lu",     5'd3,  5'd7,  1, 1, 5'd7,  1, 1, 0, 0, E_BR,   2, 0);

        for (int k = 1; k <= 3; k++) begin
            step($sformatf("memwait%0d", k), 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 0, E_FRZ, 2 + k, 0);
        end
        step("memwait_ready", 5'd1,  5'd2,  0, 0, 5'd0,  0, 0, 1, 1, E_NORM, 5, 0);
        step("idle",          5'd1,  5'd2,  0, 0, 5'd0,  0, 0, 0, 0, E_NORM, 5, 0);

        step("wait_lu",       5'd9,  5'd2,  1, 0, 5'd9,  1, 0, 1, 0, E_FRZ,  6, 0);
        step("wait_exit_lu",  5'd9,  5'd2,  1, 0, 5'd9,  1, 0, 1, 1, E_LU,   7, 0);
        step("after_lu",      5'd9,  5'd2,  1, 0, 5'd9,  0, 0, 0, 0, E_NORM, 7, 0);

        step("rstwait1",      5'd1,  5'd2,  0, 0, 5'd0,  0, 0, 1, 0, E_FRZ,  8, 0);
        step("rstwait2",      5'd1,  5'd2,  0, 0, 5'd0,  0, 0, 1, 0, E_FRZ,  9, 0);
        reset_check("rst_midwait");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_run",  5'd1,  5'd2,  0, 0, 5'd0,  0, 0, 0, 0, E_NORM, 0, 0);

        for (int k = 1; k <= 17; k++) begin
            step($sformatf("timeout%0d", k), 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1, 0, E_FRZ, k,
                 (k >= 16) ? 1'b1 : 1'b0);
        end
        step("err_held",      5'd1,  5'd2,  0, 0, 5'd0,  0, 0, 1, 1, E_FRZ,  18, 1);
        reset_check("rst_err");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_err_run",  5'd1,  5'd2,  0, 0, 5'd0,  0, 0, 0, 0, E_NORM, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
